// File: rtl/game_pkg.sv
// Shared widths, limits and fruit bit positions for the game-state datapath.
package game_pkg;

    localparam int unsigned SCORE_W   = 10;
    localparam int unsigned FRUIT_W   = 4;
    localparam int unsigned LIVES_W   = 2;
    localparam int unsigned LIVES_MAX = 3;
    localparam int unsigned COUNT_W   = 32;

    // Bit index of each fruit in the eaten-fruit mask
    localparam int unsigned APPLE  = 0;
    localparam int unsigned PEAS   = 1;
    localparam int unsigned GRAPES = 2;
    localparam int unsigned DRINK  = 3;

    // Clamp an 8-bit lives-lost write to the saturation limit so it never wraps in 2 bits
    function automatic logic [LIVES_W-1:0] sat_lives(input logic [7:0] v, input int unsigned max);
        logic [LIVES_W-1:0] r;
        if (v >= 8'(max)) begin
            r = LIVES_W'(max);
        end else begin
            r = v[LIVES_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running modulo-TICK_CYCLES counter; emits a one-cycle wrap pulse while enabled.
module tick_prescaler #(
    parameter int unsigned TICK_CYCLES = 50_000_000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic clr_i,
    output logic wrap_o
);

    localparam int unsigned CntW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TICK_CYCLES - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Wrap is flagged in the cycle the counter sits at its top value with counting enabled
    always_comb begin
        wrap_o = en_i && !clr_i && (cnt_q == CntMax);
    end

    // Next count: clear wins, otherwise advance (wrapping) only when enabled
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/game_state_regs.sv
// Game-state register file (score, fruit mask, lives lost, high score) and seconds countdown.
module game_state_regs
    import game_pkg::*;
#(
    parameter int unsigned TICK_CYCLES  = 50_000_000,
    parameter int unsigned GAME_SECONDS = 120,
    parameter int unsigned LIVES_MAX    = game_pkg::LIVES_MAX
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 restart,
    input  logic                 Load_S,
    input  logic [SCORE_W-1:0]   score_to_reg,
    input  logic                 Load_F,
    input  logic [FRUIT_W-1:0]   fruits_to_reg,
    input  logic                 Load_L,
    input  logic [7:0]           lives_to_reg,
    input  logic                 timer_en,
    input  logic                 win,
    input  logic                 lose,
    output logic [SCORE_W-1:0]   score_from_reg,
    output logic [FRUIT_W-1:0]   fruits_from_reg,
    output logic [LIVES_W-1:0]   lives_from_reg,
    output logic [COUNT_W-1:0]   counter,
    output logic                 tick_sec,
    output logic [SCORE_W-1:0]   hi_score
);

    localparam logic [COUNT_W-1:0] CountReload = COUNT_W'(GAME_SECONDS);

    logic [SCORE_W-1:0] score_q, score_d;
    logic [FRUIT_W-1:0] fruits_q, fruits_d;
    logic [LIVES_W-1:0] lives_q, lives_d;
    logic [COUNT_W-1:0] counter_q, counter_d;
    logic               tick_q, tick_d;
    logic [SCORE_W-1:0] hi_q, hi_d;
    logic               timer_run;
    logic               sec_wrap;

    // Timer only advances while playing; terminal flags and restart freeze it
    always_comb begin
        timer_run = timer_en && !win && !lose && !restart;
    end

    tick_prescaler #(
        .TICK_CYCLES (TICK_CYCLES)
    ) u_sec_prescaler (
        .clk_i  (Clk),
        .rst_ni (Reset_n),
        .en_i   (timer_run),
        .clr_i  (restart),
        .wrap_o (sec_wrap)
    );

    // Next-state for round registers: restart overrides every write strobe and tick
    always_comb begin
        score_d   = score_q;
        fruits_d  = fruits_q;
        lives_d   = lives_q;
        counter_d = counter_q;
        tick_d    = 1'b0;
        if (restart) begin
            score_d   = '0;
            fruits_d  = '0;
            lives_d   = '0;
            counter_d = CountReload;
        end else begin
            if (Load_S) begin
                score_d = score_to_reg;
            end
            if (Load_F) begin
                fruits_d = fruits_to_reg;
            end
            if (Load_L) begin
                lives_d = sat_lives(lives_to_reg, LIVES_MAX);
            end
            // Expired countdown stays at zero and stops ticking
            if (sec_wrap && (counter_q != '0)) begin
                counter_d = counter_q - 1'b1;
                tick_d    = 1'b1;
            end
        end
    end

    // High score tracks the registered score, so it trails a new best by one cycle
    always_comb begin
        hi_d = hi_q;
        if (score_q > hi_q) begin
            hi_d = score_q;
        end
    end

    // State registers
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            score_q   <= '0;
            fruits_q  <= '0;
            lives_q   <= '0;
            counter_q <= CountReload;
            tick_q    <= 1'b0;
            hi_q      <= '0;
        end else begin
            score_q   <= score_d;
            fruits_q  <= fruits_d;
            lives_q   <= lives_d;
            counter_q <= counter_d;
            tick_q    <= tick_d;
            hi_q      <= hi_d;
        end
    end

    // Outputs come straight from flops
    always_comb begin
        score_from_reg  = score_q;
        fruits_from_reg = fruits_q;
        lives_from_reg  = lives_q;
        counter         = counter_q;
        tick_sec        = tick_q;
        hi_score        = hi_q;
    end

endmodule

// File: tb/tb_game_state_regs.sv
// Directed and random checks of game_state_regs against a behavioural reference model.
module tb_game_state_regs;

    localparam int unsigned TICK  = 4;
    localparam int unsigned GSECS = 3;
    localparam int unsigned LMAX  = 3;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        restart, Load_S, Load_F, Load_L, timer_en, win, lose;
    logic [9:0]  score_to_reg;
    logic [3:0]  fruits_to_reg;
    logic [7:0]  lives_to_reg;
    logic [9:0]  score_from_reg, hi_score;
    logic [3:0]  fruits_from_reg;
    logic [1:0]  lives_from_reg;
    logic [31:0] counter;
    logic        tick_sec;

    int n_asserts = 0;
    int n_fails   = 0;

    // Reference model state: plain game quantities
    int unsigned m_score, m_fruits, m_lives, m_secs, m_runs, m_hi;
    bit          m_tick;

    game_state_regs #(
        .TICK_CYCLES  (TICK),
        .GAME_SECONDS (GSECS),
        .LIVES_MAX    (LMAX)
    ) dut (
        .Clk             (Clk),
        .Reset_n         (Reset_n),
        .restart         (restart),
        .Load_S          (Load_S),
        .score_to_reg    (score_to_reg),
        .Load_F          (Load_F),
        .fruits_to_reg   (fruits_to_reg),
        .Load_L          (Load_L),
        .lives_to_reg    (lives_to_reg),
        .timer_en        (timer_en),
        .win             (win),
        .lose            (lose),
        .score_from_reg  (score_from_reg),
        .fruits_from_reg (fruits_from_reg),
        .lives_from_reg  (lives_from_reg),
        .counter         (counter),
        .tick_sec        (tick_sec),
        .hi_score        (hi_score)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_asserts++;
        assert (got === exp)
        else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".score"},   32'(score_from_reg),  m_score);
        chk({tag, ".fruits"},  32'(fruits_from_reg), m_fruits);
        chk({tag, ".lives"},   32'(lives_from_reg),  m_lives);
        chk({tag, ".counter"}, counter,              m_secs);
        chk({tag, ".tick"},    32'(tick_sec),        32'(m_tick));
        chk({tag, ".hi"},      32'(hi_score),        m_hi);
    endtask

    task automatic model_reset();
        m_score = 0; m_fruits = 0; m_lives = 0; m_secs = GSECS;
        m_runs = 0; m_tick = 0; m_hi = 0;
    endtask

    // One clock edge of game behaviour, from the inputs held across it
    task automatic model_edge();
        bit running;
        running = timer_en && !win && !lose && !restart;
        if (m_score > m_hi) m_hi = m_score;
        m_tick = 0;
        if (restart) begin
            m_score = 0; m_fruits = 0; m_lives = 0; m_secs = GSECS; m_runs = 0;
        end else begin
            if (Load_S) m_score = score_to_reg;
            if (Load_F) m_fruits = fruits_to_reg;
            if (Load_L) m_lives = (lives_to_reg >= LMAX) ? LMAX : lives_to_reg;
            if (running) begin
                m_runs++;
                if ((m_runs % TICK) == 0 && m_secs != 0) begin
                    m_secs--;
                    m_tick = 1;
                end
            end
        end
    endtask

    task automatic idle();
        restart = 0; Load_S = 0; Load_F = 0; Load_L = 0;
        win = 0; lose = 0;
    endtask

    task automatic step(input string tag);
        @(posedge Clk);
        model_edge();
        @(negedge Clk);
        check_all(tag);
    endtask

    task automatic async_reset(input string tag);
        #2 Reset_n = 0;
        #1 model_reset();
        check_all(tag);
        @(negedge Clk);
        Reset_n = 1;
    endtask

    initial begin
        Reset_n = 1; timer_en = 0;
        score_to_reg = 0; fruits_to_reg = 0; lives_to_reg = 0;
        idle();
        model_reset();
        @(negedge Clk);
        async_reset("por");

        // Mid-round reset wipes a loaded score immediately
        Load_S = 1; score_to_reg = 10'd300; timer_en = 1;
        step("t1_load300");
        idle();
        step("t1_run");
        async_reset("t1_reset");
        chk("t1_counter_reload", counter, GSECS);

        // Score write latency and one-cycle-later high score
        timer_en = 0;
        Load_S = 1; score_to_reg = 10'd50;
        step("t2_score");
        chk("t2_hi_lag", 32'(hi_score), 0);
        idle();
        step("t2_hi");
        chk("t2_hi50", 32'(hi_score), 50);

        // Lives saturation, then restart keeps high score
        Load_L = 1; lives_to_reg = 8'd7;
        step("t3_lives_sat");
        chk("t3_lives3", 32'(lives_from_reg), 3);
        idle(); restart = 1;
        step("t3_restart");
        chk("t3_hi_kept", 32'(hi_score), 50);

        // Countdown to expiry and hold at zero
        idle(); timer_en = 1;
        for (int i = 0; i < 4 * TICK + 3; i++) step("t4_count");
        chk("t4_expired", counter, 0);

        // Freeze with lose mid-second, toggle enable, then resume
        restart = 1;
        step("t5_restart");
        idle();
        step("t5_run"); step("t5_run");
        lose = 1;
        for (int i = 0; i < 3; i++) step("t5_lose");
        lose = 0; timer_en = 0;
        step("t5_off");
        timer_en = 1;
        for (int i = 0; i < 6; i++) step("t5_resume");

        // Restart beats a simultaneous fruit write
        restart = 1; Load_F = 1; fruits_to_reg = 4'b0001;
        step("t6_restart_fruit");
        chk("t6_fruits0", 32'(fruits_from_reg), 0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            restart       = ($urandom_range(0, 19) == 0);
            Load_S        = ($urandom_range(0, 3) == 0);
            Load_F        = ($urandom_range(0, 3) == 0);
            Load_L        = ($urandom_range(0, 3) == 0);
            timer_en      = ($urandom_range(0, 3) != 0);
            win           = ($urandom_range(0, 15) == 0);
            lose          = ($urandom_range(0, 15) == 0);
            score_to_reg  = 10'($urandom);
            fruits_to_reg = 4'($urandom);
            lives_to_reg  = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom);
            step("rand");
        end
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
